// File: rtl/wb_pkg.sv
// Shared types and the load-data extension helper for the register-file writeback block.
package wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_op_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } pending_entry_t;

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      funct3,
                                                  input logic [1:0]      offset);
    logic [7:0]  b;
    logic [15:0] h;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      load_extend = {{24{b[7]}}, b};
      LBU:     load_extend = {24'b0, b};
      LH:      load_extend = {{16{h[15]}}, h};
      LHU:     load_extend = {16'b0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/pending_fifo.sv
// In-order queue of outstanding loads; exposes per-slot rd and valid bits for the pending mask.
module pending_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  pending_entry_t push_entry_i,
  input  logic           pop_i,
  output pending_entry_t head_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [DEPTH-1:0] valid_o,
  output logic [4:0]     rd_o [DEPTH]
);

  localparam int AW = $clog2(DEPTH);

  pending_entry_t   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [DEPTH-1:0] valid_q;

  // Callers gate push with !full and pop with !empty, so slots never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_i) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) rd_o[i] = mem_q[i].rd;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign valid_o = valid_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port: merges ALU results and in-order load responses, loads win.
// Optional WB_STATS_EN adds load and ALU-stall counters.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rd,
  input  logic [2:0]      issue_funct3,
  input  logic [1:0]      issue_offset,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     pending_mask,
  output logic            err_unexpected
`ifdef WB_STATS_EN
  ,
  output logic [31:0]     stat_loads,
  output logic [31:0]     stat_alu_stalls
`endif
);

  pending_entry_t   head, push_entry;
  logic             full, empty, push, pop;
  logic [DEPTH-1:0] slot_valid;
  logic [4:0]       slot_rd [DEPTH];

  logic            wb_we_q, err_q;
  logic [4:0]      wb_addr_q;
  logic [XLEN-1:0] wb_data_q;

  assign push_entry = '{rd: issue_rd, funct3: issue_funct3, offset: issue_offset};
  assign issue_ready = !full;
  assign push        = issue_valid && !full;
  assign pop         = mem_rvalid && !empty;
  assign alu_ready   = !pop;

  pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .valid_o      (slot_valid),
    .rd_o         (slot_rd)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pending_mask[slot_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // Address/data follow the winning source even for x0; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= mem_rvalid && empty;
      if (pop) begin
        wb_we_q   <= (head.rd != 5'd0);
        wb_addr_q <= head.rd;
        wb_data_q <= load_extend(mem_rdata, head.funct3, head.offset);
      end else if (alu_valid) begin
        wb_we_q   <= (alu_rd != 5'd0);
        wb_addr_q <= alu_rd;
        wb_data_q <= alu_data;
      end else begin
        wb_we_q   <= 1'b0;
      end
    end
  end

  assign wb_we          = wb_we_q;
  assign wb_addr        = wb_addr_q;
  assign wb_data        = wb_data_q;
  assign err_unexpected = err_q;

`ifdef WB_STATS_EN
  logic [31:0] stat_loads_q, stat_alu_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q      <= '0;
      stat_alu_stalls_q <= '0;
    end else begin
      if (pop)                     stat_loads_q      <= stat_loads_q + 1'b1;
      if (alu_valid && !alu_ready) stat_alu_stalls_q <= stat_alu_stalls_q + 1'b1;
    end
  end

  assign stat_loads      = stat_loads_q;
  assign stat_alu_stalls = stat_alu_stalls_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;

  logic        clk, rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_funct3;
  logic [1:0]  issue_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] pending_mask;
  logic        err_unexpected;
`ifdef WB_STATS_EN
  logic [31:0] stat_loads, stat_alu_stalls;
`endif

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.XLEN(32), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rd       (issue_rd),
    .issue_funct3   (issue_funct3),
    .issue_offset   (issue_offset),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .pending_mask   (pending_mask),
    .err_unexpected (err_unexpected)
`ifdef WB_STATS_EN
    ,
    .stat_loads     (stat_loads),
    .stat_alu_stalls(stat_alu_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_funct3 = 0; issue_offset = 0;
    mem_rvalid = 0; mem_rdata = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", wb_we); end
    total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_unexpected); end
    total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL reset_mask got=%h exp=0", pending_mask); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready); end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL alu_ready got=%0b exp=1", alu_ready); end
    step();
    idle();
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'h1234})
      begin bad++; $display("FAIL alu_wb got=%0b/%0d/%h exp=1/5/00001234", wb_we, wb_addr, wb_data); end
    step();
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL alu_we_one_cycle got=%0b exp=0", wb_we); end
  endtask

  task automatic test_load_ext(input logic [2:0] f3, input logic [31:0] exp_data);
    issue_valid = 1; issue_rd = 7; issue_funct3 = f3; issue_offset = 2;
    step();
    idle();
    total++; if (pending_mask !== 32'h0000_0080) begin bad++; $display("FAIL ext_mask_set f3=%0d got=%h exp=00000080", f3, pending_mask); end
    step();
    mem_rvalid = 1; mem_rdata = 32'h0080_0000;
    #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL ext_alu_ready got=%0b exp=0", alu_ready); end
    total++; if (pending_mask !== 32'h0000_0080) begin bad++; $display("FAIL ext_mask_pop_cycle got=%h exp=00000080", pending_mask); end
    step();
    idle();
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd7, exp_data})
      begin bad++; $display("FAIL ext_wb f3=%0d got=%0b/%0d/%h exp=1/7/%h", f3, wb_we, wb_addr, wb_data, exp_data); end
    total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL ext_mask_clear got=%h exp=0", pending_mask); end
    step();
  endtask

  task automatic test_collision();
    issue_valid = 1; issue_rd = 9; issue_funct3 = 3'b101; issue_offset = 2;
    step();
    idle();
    mem_rvalid = 1; mem_rdata = 32'hBEEF_0000;
    alu_valid = 1; alu_rd = 3; alu_data = 32'hAAAA_5555;
    #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL coll_alu_ready got=%0b exp=0", alu_ready); end
    step();
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL coll_alu_ready_after got=%0b exp=1", alu_ready); end
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd9, 32'h0000_BEEF})
      begin bad++; $display("FAIL coll_load_wb got=%0b/%0d/%h exp=1/9/0000beef", wb_we, wb_addr, wb_data); end
    step();
    idle();
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd3, 32'hAAAA_5555})
      begin bad++; $display("FAIL coll_alu_wb got=%0b/%0d/%h exp=1/3/aaaa5555", wb_we, wb_addr, wb_data); end
    step();
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_rd = 5'(10 + i); issue_funct3 = 3'b010; issue_offset = 0;
      step();
    end
    issue_rd = 14;
    mem_rvalid = 1; mem_rdata = 32'h1000;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full got=%0b exp=0", issue_ready); end
    total++; if (pending_mask !== 32'h0000_3C00) begin bad++; $display("FAIL fill_mask got=%h exp=00003c00", pending_mask); end
    step();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop got=%0b exp=1", issue_ready); end
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd10, 32'h1000})
      begin bad++; $display("FAIL fill_wb0 got=%0b/%0d/%h exp=1/10/00001000", wb_we, wb_addr, wb_data); end
    for (int k = 1; k < 8; k++) begin
      issue_valid = (k <= 4); issue_rd = 5'(13 + k);
      mem_rvalid = 1; mem_rdata = 32'h1000 + 32'(k);
      step();
      total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'(10 + k), 32'h1000 + 32'(k)})
        begin bad++; $display("FAIL wrap_wb k=%0d got=%0b/%0d/%h exp=1/%0d/%h", k, wb_we, wb_addr, wb_data, 10 + k, 32'h1000 + k); end
    end
    idle();
    total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL wrap_mask_empty got=%h exp=0", pending_mask); end
    step();
  endtask

  task automatic test_double_pending();
    issue_valid = 1; issue_rd = 4; issue_funct3 = 3'b010;
    step(); step();
    idle();
    mem_rvalid = 1; mem_rdata = 32'h11;
    step();
    idle();
    total++; if (pending_mask !== 32'h0000_0010) begin bad++; $display("FAIL dbl_mask_one_left got=%h exp=00000010", pending_mask); end
    mem_rvalid = 1; mem_rdata = 32'h22;
    step();
    idle();
    total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL dbl_mask_clear got=%h exp=0", pending_mask); end
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd4, 32'h22})
      begin bad++; $display("FAIL dbl_wb got=%0b/%0d/%h exp=1/4/00000022", wb_we, wb_addr, wb_data); end
    step();
  endtask

  task automatic test_unexpected_x0();
    mem_rvalid = 1; mem_rdata = 32'hDEAD;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL unexp_alu_ready got=%0b exp=1", alu_ready); end
    step();
    idle();
    total++; if ({err_unexpected, wb_we} !== 2'b10) begin bad++; $display("FAIL unexp_pulse got=%0b/%0b exp=1/0", err_unexpected, wb_we); end
    step();
    total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL unexp_one_cycle got=%0b exp=0", err_unexpected); end
    // issue into empty queue with a simultaneous response: no pass-through
    issue_valid = 1; issue_rd = 6; issue_funct3 = 3'b010;
    mem_rvalid = 1; mem_rdata = 32'h66;
    step();
    idle();
    total++; if ({err_unexpected, wb_we} !== 2'b10) begin bad++; $display("FAIL passthru_err got=%0b/%0b exp=1/0", err_unexpected, wb_we); end
    total++; if (pending_mask !== 32'h0000_0040) begin bad++; $display("FAIL passthru_mask got=%h exp=00000040", pending_mask); end
    mem_rvalid = 1; mem_rdata = 32'h67;
    step();
    idle();
    total++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd6, 32'h67})
      begin bad++; $display("FAIL passthru_wb got=%0b/%0d/%h exp=1/6/00000067", wb_we, wb_addr, wb_data); end
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
    step();
    idle();
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL alu_x0_we got=%0b exp=0", wb_we); end
    issue_valid = 1; issue_rd = 0; issue_funct3 = 3'b010;
    step();
    idle();
    total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL x0_mask got=%h exp=0", pending_mask); end
    mem_rvalid = 1; mem_rdata = 32'h77;
    step();
    idle();
    total++; if ({wb_we, err_unexpected} !== 2'b00) begin bad++; $display("FAIL x0_load got=%0b/%0b exp=0/0", wb_we, err_unexpected); end
    mem_rvalid = 1; mem_rdata = 32'h78;
    step();
    idle();
    total++; if (err_unexpected !== 1'b1) begin bad++; $display("FAIL x0_popped got=%0b exp=1", err_unexpected); end
    step();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_funct3 = 3'b010;
    issue_rd = 20; step();
    issue_rd = 21; step();
    idle();
    total++; if (pending_mask !== 32'h0030_0000) begin bad++; $display("FAIL rstmid_mask_before got=%h exp=00300000", pending_mask); end
    rst = 1;
    step();
    rst = 0;
    total++; if ({pending_mask, issue_ready} !== {32'd0, 1'b1})
      begin bad++; $display("FAIL rstmid_state got=%h/%0b exp=0/1", pending_mask, issue_ready); end
    mem_rvalid = 1; mem_rdata = 32'h99;
    step();
    idle();
    total++; if ({err_unexpected, wb_we} !== 2'b10) begin bad++; $display("FAIL rstmid_unexp got=%0b/%0b exp=1/0", err_unexpected, wb_we); end
    step();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_alu();
    test_load_ext(3'b000, 32'hFFFF_FF80);
    test_load_ext(3'b100, 32'h0000_0080);
    test_collision();
    test_fill_wrap();
    test_double_pending();
    test_unexpected_x0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Drives the register-file write port (write enable, destination index, write data) for the single-core RV32I CPU.
- Merges two result sources:
  - single-cycle ALU results;
  - multi-cycle load responses from data memory.
- Tracks outstanding loads in an in-order queue and sign/zero-extends load data.
- Exports a per-register pending mask that the hazard logic uses to stall readers of registers still waiting on loads.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- DEPTH, 4, maximum outstanding loads; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  load issued to memory this cycle
- issue_ready  out  1  queue can accept an issue
- issue_rd  in  5  load destination register
- issue_funct3  in  3  load funct3 (LB/LH/LW/LBU/LHU)
- issue_offset  in  2  load address bits [1:0]
- mem_rvalid  in  1  memory read response valid; responses arrive in issue order
- mem_rdata  in  32  aligned memory word
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- wb_we  out  1  register-file write enable
- wb_addr  out  5  register-file write index
- wb_data  out  32  register-file write data
- pending_mask  out  32  bit i set while a load to register xi is outstanding
- err_unexpected  out  1  one-cycle pulse: response arrived with empty queue

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - wb_we=0, wb_addr=0, wb_data=0, err_unexpected=0;
  - queue empty, so pending_mask=0 and issue_ready=1.
- Reset mid-operation discards all queued loads; responses arriving afterwards count as unexpected.
- Issue:
  - Handshake completes when issue_valid && issue_ready.
  - On handshake, {rd, funct3, offset} is enqueued.
  - issue_ready = !full (registered count); there is no bypass when full, even if a pop occurs the same cycle.
- Response, when mem_rvalid=1:
  - If the queue is non-empty, pop the head and write back the extended data.
  - If the queue is empty, drop the data and pulse err_unexpected the next cycle.
  - A response in the same cycle as an issue into an empty queue is unexpected; no same-cycle pass-through.
- Arbitration:
  - Load responses have priority.
  - alu_ready = !(mem_rvalid && queue non-empty), combinational.
  - An ALU result is written only when alu_valid && alu_ready.
- Writeback timing:
  - Outputs are registered, one-cycle latency from the accepted event.
  - wb_we=1 for exactly one cycle per accepted event.
  - wb_we is forced 0 when the destination is x0; a load to x0 still pops the queue.
- Extension, by funct3:
  - 000 LB: sign-extend byte[offset].
  - 100 LBU: zero-extend byte[offset].
  - 001 LH: sign-extend halfword[offset[1]]; offset[0] is ignored.
  - 101 LHU: zero-extend halfword[offset[1]]; offset[0] is ignored.
  - 010 LW and all other codes: full word, offset ignored.
- pending_mask:
  - Combinational OR of the decoded rd over all valid queue entries; bit 0 is always 0.
  - A register with two outstanding loads stays set until both retire.
  - The bit clears in the cycle after the pop, which is the same cycle wb_we writes it.
- Queue pointers wrap modulo DEPTH. Count runs 0..DEPTH; full = (count==DEPTH).

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - adds outputs stat_loads (32-bit) and stat_alu_stalls (32-bit), both reset to 0;
  - stat_loads increments per popped load;
  - stat_alu_stalls increments each cycle with alu_valid && !alu_ready;
  - both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - XLEN constant;
  - load_op_e enum (LB, LH, LW, LBU, LHU, encoded as funct3);
  - pending_entry_t struct {rd, funct3, offset};
  - pure function load_extend(word, funct3, offset).
- Sub-module pending_fifo: synchronous DEPTH-entry FIFO of pending_entry_t, exposing entries and valid bits for mask generation.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0x1234 -> next cycle wb_we=1, wb_addr=5, wb_data=0x1234; alu_ready stays 1.
- LB, offset 2 to x7; response 0x0080_0000 -> wb_data=0xFFFF_FF80; pending_mask bit 7 set from issue until the writeback cycle. LBU, same case -> 0x0000_0080.
- Collision: response for LHU, offset 2, rdata 0xBEEF_0000, same cycle as an ALU result to x3 -> alu_ready=0, load writes 0x0000_BEEF; ALU result written the following cycle.
- Fill 4 loads -> issue_ready=0 on the 5th; one response -> issue_ready=1 the next cycle; queue order preserved through pointer wrap (8 loads total).
- Unexpected/x0: response with empty queue -> err_unexpected pulse, no write. ALU write to x0 -> wb_we=0. Load to x0 pops the queue with wb_we=0.
- Reset with 2 loads pending -> pending_mask=0, issue_ready=1; a following response -> err_unexpected.
